circular_window_buffer: RTL and testbench
=========================================

Name: circular_window_buffer

Overview:
Parametrised successor to the team's multi-port row buffer. Rows are stored in a circular FIFO with head and tail pointers and occupancy tracking, so producers append rows instead of addressing them.
- Write side: appends 1..PAR_WRITE rows per cycle at the tail.
- Read side: PAR_READ lanes read combinationally at offsets relative to the head (sliding-window access for the PE array), then retire 0..PAR_READ rows per cycle.

Parameters:
ROW_SIZE, 8, bits per row
COLUMNS, 32, depth in rows; power of two, >= PAR_WRITE + PAR_READ
PAR_WRITE, 4, max rows appended per cycle
PAR_READ, 4, read lanes and max rows popped per cycle

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
wen  in  1  append request
wcnt  in  $clog2(PAR_WRITE+1)  rows valid in din; lanes 0..wcnt-1, lane 0 oldest
din  in  ROW_SIZE*PAR_WRITE  row data, lane i at [i*ROW_SIZE +: ROW_SIZE]
wready  out  1  free rows >= PAR_WRITE
roff  in  PAR_READ*$clog2(COLUMNS)  per-lane offset from head
dout  out  ROW_SIZE*PAR_READ  per-lane row data
rvalid  out  PAR_READ  lane j offset < count
pop  in  1  retire request
pop_cnt  in  $clog2(PAR_READ+1)  rows to retire
count  out  $clog2(COLUMNS)+1  occupancy
full  out  1  count == COLUMNS
empty  out  1  count == 0

Behaviour:
- Reset (rst=1 at edge): head=0, tail=0, count=0, all memory rows zeroed. Reset overrides wen and pop in the same cycle.
- Outputs after reset: empty=1, full=0, wready=1, rvalid=0, dout=0.
- Write acceptance: wen && wready && wcnt!=0. Writes are dropped when wready=0 or wcnt=0. wcnt>PAR_WRITE is clamped to PAR_WRITE.
- Write placement: lane i goes to mem[(tail+i) mod COLUMNS] for i<wcnt; tail += wcnt mod COLUMNS. Wrap-around is natural via pointer width.
- Pop acceptance: pop && pop_cnt!=0 && pop_cnt<=PAR_READ && pop_cnt<=count. Otherwise the pop is ignored entirely; no partial pop.
- Pop effect: head += pop_cnt mod COLUMNS.
- Occupancy: count_next = count + wacc - pacc. Simultaneous append and pop are both applied in the same cycle.
- wready is derived from the registered count only; a same-cycle pop does not free space for a same-cycle write. This keeps wready off the pop path.
- Read path: combinational. dout lane j = mem[(head + roff_j) mod COLUMNS]; rvalid_j = (roff_j < count).
- Read latency: a row appended in cycle t is readable from cycle t+1. A pop in cycle t shifts lane addressing from cycle t+1.
- dout is undefined-but-stable (stale row data) when rvalid_j=0; consumers must qualify with rvalid.
- All state updates use non-blocking assignment. No simulation I/O inside the synthesizable body.
- count, full and empty are registered-state decodes, with no combinational path from wen or pop.

Optional Feature:
CWB_ERR_STICKY_EN
- Defined: adds outputs err_ovf and err_unf (1 bit each), both 0 at reset and cleared only by rst.
- err_ovf sets when wen=1 with wcnt!=0 and wready=0.
- err_unf sets when pop=1 with pop_cnt > count or pop_cnt > PAR_READ.
- Undefined: the ports are absent and illegal requests are silently dropped, exactly as above.

Decomposition:
- Package cwb_pkg holds:
  - localparam helpers AW=$clog2(COLUMNS) and CW=AW+1;
  - ptr_t/cnt_t width typedefs;
  - a function for the modular add used by the pointers.
- Sub-module cwb_ptr_ctrl owns head, tail, count, acceptance logic, wready/full/empty and the optional error flags.
- The top level holds the memory array, write lanes and read lanes.

Test Plan:
- Reset: assert rst 2 cycles -> count=0, empty=1, full=0, wready=1, rvalid=4'b0000, dout=0.
- Append and read: wen, wcnt=4, din lanes 0x11,0x22,0x33,0x44 -> next cycle count=4.
  - roff={3,2,1,0} -> dout={0x44,0x33,0x22,0x11}, rvalid=4'b1111.
  - roff lane0=4 -> rvalid[0]=0.
- Fill: 8 appends of wcnt=4 -> count=32, full=1, wready=0; a 9th append is dropped and count stays 32 (err_ovf=1 if enabled).
- Wrap: from full, pop_cnt=4 twice -> count=24, head=8.
  - Then append 0xA0..0xA3 -> written at physical rows 0..3, count=28.
  - Then roff 24..27 returns 0xA0..0xA3.
- Simultaneous and illegal pop:
  - count=10, append wcnt=4 and pop pop_cnt=2 in the same cycle -> count=12.
  - With count=2, pop pop_cnt=3 -> ignored, count stays 2 (err_unf=1 if enabled).
- Reset mid-operation: count=12 with wen and pop asserted in the rst cycle -> count=0, empty=1, dout=0 next cycle.

Source files
------------

// File: rtl/cwb_pkg.sv
// Shared widths, pointer typedefs and modular-add helper for the circular window buffer.
package cwb_pkg;
  localparam int DEF_COLUMNS = 32;
  localparam int AW = $clog2(DEF_COLUMNS);
  localparam int CW = AW + 1;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  // COLUMNS is a power of two, so masking is the modulo.
  function automatic logic [31:0] mod_add(input logic [31:0] a, input logic [31:0] b,
                                          input int unsigned cols);
    return (a + b) & (cols - 1);
  endfunction
endpackage

// File: rtl/cwb_ptr_ctrl.sv
// Head/tail/occupancy control and request acceptance for the circular window buffer.
// Optional sticky error flags under CWB_ERR_STICKY_EN.
module cwb_ptr_ctrl
  import cwb_pkg::*;
#(
  parameter int COLUMNS   = DEF_COLUMNS,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 4,
  localparam int PW  = $clog2(COLUMNS),
  localparam int PCW = PW + 1,
  localparam int WCW = $clog2(PAR_WRITE + 1),
  localparam int RCW = $clog2(PAR_READ + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wen,
  input  logic [WCW-1:0] wcnt,
  input  logic           pop,
  input  logic [RCW-1:0] pop_cnt,
  output logic [PW-1:0]  head,
  output logic [PW-1:0]  tail,
  output logic [PCW-1:0] count,
  output logic [WCW-1:0] wacc,
  output logic           wready,
  output logic           full,
`ifdef CWB_ERR_STICKY_EN
  output logic           err_ovf,
  output logic           err_unf,
`endif
  output logic           empty
);
  logic [WCW-1:0] wcnt_clamp;
  logic [RCW-1:0] pacc;
  logic           pop_ok;

  assign wcnt_clamp = (wcnt > WCW'(PAR_WRITE)) ? WCW'(PAR_WRITE) : wcnt;

  // Space check sees registered count only; a same-cycle pop never frees room.
  assign wready = (PCW'(COLUMNS) - count) >= PCW'(PAR_WRITE);
  assign full   = count == PCW'(COLUMNS);
  assign empty  = count == '0;

  assign wacc   = (wen && wready && wcnt != '0) ? wcnt_clamp : '0;
  assign pop_ok = pop && pop_cnt != '0 && pop_cnt <= RCW'(PAR_READ) && PCW'(pop_cnt) <= count;
  assign pacc   = pop_ok ? pop_cnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= PW'(mod_add(32'(head), 32'(pacc), COLUMNS));
      tail  <= PW'(mod_add(32'(tail), 32'(wacc), COLUMNS));
      count <= count + PCW'(wacc) - PCW'(pacc);
    end
  end

`ifdef CWB_ERR_STICKY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      if (wen && wcnt != '0 && !wready) err_ovf <= 1'b1;
      if (pop && (PCW'(pop_cnt) > count || pop_cnt > RCW'(PAR_READ))) err_unf <= 1'b1;
    end
  end
`endif
endmodule

// File: rtl/circular_window_buffer.sv
// Circular row FIFO with multi-row append and PAR_READ head-relative read lanes.
// Define CWB_ERR_STICKY_EN to expose sticky err_ovf/err_unf flags.
module circular_window_buffer
  import cwb_pkg::*;
#(
  parameter int ROW_SIZE  = 8,
  parameter int COLUMNS   = DEF_COLUMNS,
  parameter int PAR_WRITE = 4,
  parameter int PAR_READ  = 4,
  localparam int PW  = $clog2(COLUMNS),
  localparam int PCW = PW + 1,
  localparam int WCW = $clog2(PAR_WRITE + 1),
  localparam int RCW = $clog2(PAR_READ + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [WCW-1:0]               wcnt,
  input  logic [ROW_SIZE*PAR_WRITE-1:0] din,
  output logic                         wready,
  input  logic [PAR_READ*PW-1:0]       roff,
  output logic [ROW_SIZE*PAR_READ-1:0] dout,
  output logic [PAR_READ-1:0]          rvalid,
  input  logic                         pop,
  input  logic [RCW-1:0]               pop_cnt,
  output logic [PCW-1:0]               count,
  output logic                         full,
`ifdef CWB_ERR_STICKY_EN
  output logic                         err_ovf,
  output logic                         err_unf,
`endif
  output logic                         empty
);
  logic [COLUMNS-1:0][ROW_SIZE-1:0] mem;
  logic [PW-1:0]                    head, tail;
  logic [WCW-1:0]                   wacc;
  logic [PAR_WRITE-1:0][PW-1:0]     waddr;
  logic [PAR_WRITE-1:0]             we;

  cwb_ptr_ctrl #(.COLUMNS(COLUMNS), .PAR_WRITE(PAR_WRITE), .PAR_READ(PAR_READ)) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .wen     (wen),
    .wcnt    (wcnt),
    .pop     (pop),
    .pop_cnt (pop_cnt),
    .head    (head),
    .tail    (tail),
    .count   (count),
    .wacc    (wacc),
    .wready  (wready),
    .full    (full),
`ifdef CWB_ERR_STICKY_EN
    .err_ovf (err_ovf),
    .err_unf (err_unf),
`endif
    .empty   (empty)
  );

  for (genvar i = 0; i < PAR_WRITE; i++) begin : g_wr
    assign waddr[i] = PW'(mod_add(32'(tail), 32'(i), COLUMNS));
    assign we[i]    = 32'(wacc) > 32'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else begin
      for (int i = 0; i < PAR_WRITE; i++)
        if (we[i]) mem[waddr[i]] <= din[i*ROW_SIZE +: ROW_SIZE];
    end
  end

  // Lanes read straight from registered state; wrap falls out of PW-bit addition.
  for (genvar j = 0; j < PAR_READ; j++) begin : g_rd
    logic [PW-1:0] off, raddr;
    assign off                          = roff[j*PW +: PW];
    assign raddr                        = head + off;
    assign dout[j*ROW_SIZE +: ROW_SIZE] = mem[raddr];
    assign rvalid[j]                    = PCW'(off) < count;
  end
endmodule

// File: tb/tb_circular_window_buffer.sv
// Scoreboard bench for circular_window_buffer: row-queue model plus expected-read queue.
module tb_circular_window_buffer;
  import cwb_pkg::*;
  localparam int COLS = 32, PW_ = 4, PR = 4;

  logic        clk = 1'b0, rst, wen, pop, wready, full, empty;
  logic [2:0]  wcnt, pop_cnt;
  logic [31:0] din, dout;
  logic [19:0] roff;
  logic [3:0]  rvalid;
  cnt_t        count;
`ifdef CWB_ERR_STICKY_EN
  logic err_ovf, err_unf;
  bit   m_ovf, m_unf;
`endif

  typedef struct { int lane; bit v; logic [7:0] d; } exp_t;
  int   checks = 0, failures = 0;
  int   mq[$];
  exp_t exp_q[$];
  exp_t e;

  circular_window_buffer #(.ROW_SIZE(8), .COLUMNS(COLS), .PAR_WRITE(PW_), .PAR_READ(PR)) dut (
    .clk(clk), .rst(rst), .wen(wen), .wcnt(wcnt), .din(din), .wready(wready),
    .roff(roff), .dout(dout), .rvalid(rvalid), .pop(pop), .pop_cnt(pop_cnt),
    .count(count), .full(full),
`ifdef CWB_ERR_STICKY_EN
    .err_ovf(err_ovf), .err_unf(err_unf),
`endif
    .empty(empty));

  always #5 clk = ~clk;

  // One clock with the given request; the row-queue model applies the same request.
  task automatic cycle(input bit w, input int wc, input logic [31:0] d, input bit p, input int pc);
    int wa, pa, sz;
    sz = mq.size();
    wen = w; wcnt = 3'(wc); din = d; pop = p; pop_cnt = 3'(pc);
    wa = (w && wc != 0 && (COLS - sz) >= PW_) ? ((wc > PW_) ? PW_ : wc) : 0;
    pa = (p && pc != 0 && pc <= PR && pc <= sz) ? pc : 0;
`ifdef CWB_ERR_STICKY_EN
    if (w && wc != 0 && (COLS - sz) < PW_) m_ovf = 1;
    if (p && (pc > sz || pc > PR)) m_unf = 1;
`endif
    repeat (pa) void'(mq.pop_front());
    for (int i = 0; i < wa; i++) mq.push_back(int'(d[i*8 +: 8]));
    @(posedge clk); #1;
    wen = 0; pop = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1;
    repeat (n) @(posedge clk);
    #1; rst = 0;
    mq.delete();
`ifdef CWB_ERR_STICKY_EN
    m_ovf = 0; m_unf = 0;
`endif
  endtask

  // Drive lane offsets and queue the reads the model expects.
  task automatic set_roff(input int a0, input int a1, input int a2, input int a3);
    int o[4];
    exp_t x;
    o = '{a0, a1, a2, a3};
    roff = {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    for (int j = 0; j < 4; j++) begin
      x.lane = j;
      x.v    = o[j] < mq.size();
      x.d    = x.v ? 8'(mq[o[j]]) : 8'h00;
      exp_q.push_back(x);
    end
    #1;
  endtask

  task automatic test_reset;
    wen = 0; pop = 0; wcnt = 0; pop_cnt = 0; din = 0; roff = 0;
    do_reset(2);
    roff = {5'd3, 5'd2, 5'd1, 5'd0}; #1;
    checks++;
    if ({count, empty, full, wready, rvalid} !== {6'd0, 1'b1, 1'b0, 1'b1, 4'b0000}) begin
      failures++;
      $display("FAIL reset_flags got cnt=%0d e=%b f=%b wr=%b rv=%b want 0 1 0 1 0000",
               count, empty, full, wready, rvalid);
    end
    checks++;
    if (dout !== 32'h0) begin failures++; $display("FAIL reset_dout got %h want 0", dout); end
  endtask

  task automatic test_append_read;
    cycle(1, 4, 32'h44332211, 0, 0);
    checks++;
    if (count !== 6'd4) begin failures++; $display("FAIL append_count got %0d want 4", count); end
    set_roff(0, 1, 2, 3);
    checks++;
    if (dout !== 32'h44332211 || rvalid !== 4'b1111) begin
      failures++; $display("FAIL append_read got %h rv=%b want 44332211 1111", dout, rvalid);
    end
    exp_q.delete();
    set_roff(4, 1, 2, 3);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rvalid[e.lane] !== e.v || (e.v && dout[e.lane*8 +: 8] !== e.d)) begin
        failures++; $display("FAIL append_lane%0d got v=%b d=%h want v=%b d=%h",
                             e.lane, rvalid[e.lane], dout[e.lane*8 +: 8], e.v, e.d);
      end
    end
  endtask

  task automatic test_fill;
    logic [31:0] d;
    do_reset(1);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'(64 + k*4 + i);
      cycle(1, 4, d, 0, 0);
    end
    checks++;
    if ({count, full, wready, empty} !== {6'd32, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL fill_flags got cnt=%0d f=%b wr=%b e=%b want 32 1 0 0",
                           count, full, wready, empty);
    end
    cycle(1, 4, 32'hDEADBEEF, 0, 0);
    checks++;
    if (count !== 6'd32) begin failures++; $display("FAIL fill_drop got %0d want 32", count); end
`ifdef CWB_ERR_STICKY_EN
    checks++;
    if ({err_ovf, err_unf} !== {m_ovf, m_unf}) begin
      failures++; $display("FAIL fill_err got %b%b want %b%b", err_ovf, err_unf, m_ovf, m_unf);
    end
`endif
    set_roff(0, 1, 30, 31);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rvalid[e.lane] !== e.v || (e.v && dout[e.lane*8 +: 8] !== e.d)) begin
        failures++; $display("FAIL fill_lane%0d got v=%b d=%h want v=%b d=%h",
                             e.lane, rvalid[e.lane], dout[e.lane*8 +: 8], e.v, e.d);
      end
    end
  endtask

  task automatic test_wrap;
    cycle(0, 0, 0, 1, 4);
    cycle(0, 0, 0, 1, 4);
    checks++;
    if (count !== 6'd24) begin failures++; $display("FAIL wrap_pop got %0d want 24", count); end
    cycle(1, 4, 32'hA3A2A1A0, 0, 0);
    checks++;
    if (count !== 6'd28) begin failures++; $display("FAIL wrap_append got %0d want 28", count); end
    set_roff(24, 25, 26, 27);
    checks++;
    if (dout !== 32'hA3A2A1A0 || rvalid !== 4'b1111) begin
      failures++; $display("FAIL wrap_read got %h rv=%b want a3a2a1a0 1111", dout, rvalid);
    end
    exp_q.delete();
    set_roff(0, 23, 27, 28);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rvalid[e.lane] !== e.v || (e.v && dout[e.lane*8 +: 8] !== e.d)) begin
        failures++; $display("FAIL wrap_lane%0d got v=%b d=%h want v=%b d=%h",
                             e.lane, rvalid[e.lane], dout[e.lane*8 +: 8], e.v, e.d);
      end
    end
  endtask

  task automatic test_simul_illegal;
    int want[5];
    do_reset(1);
    cycle(1, 4, 32'h03020100, 0, 0);
    cycle(1, 4, 32'h07060504, 0, 0);
    cycle(1, 2, 32'hFFFF0908, 0, 0);
    cycle(1, 4, 32'h0D0C0B0A, 1, 2);
    checks++;
    if (count !== 6'd12) begin failures++; $display("FAIL simul_count got %0d want 12", count); end
    cycle(0, 0, 0, 1, 4);
    cycle(0, 0, 0, 1, 4);
    cycle(0, 0, 0, 1, 2);
    // Illegal/empty requests: pop 3 of 2, pop 0, write 0 rows, then an over-wide write.
    cycle(0, 0, 0, 1, 3);
    want[0] = mq.size();
    cycle(0, 0, 0, 1, 0);
    cycle(1, 0, 32'h55555555, 0, 0);
    want[1] = mq.size();
    cycle(1, 7, 32'h13121110, 0, 0);
    checks++;
    if (want[0] != 2 || want[1] != 2 || count !== 6'd6) begin
      failures++; $display("FAIL illegal_count got %0d want 6 (model %0d %0d)", count, want[0], want[1]);
    end
`ifdef CWB_ERR_STICKY_EN
    checks++;
    if ({err_ovf, err_unf} !== {m_ovf, m_unf}) begin
      failures++; $display("FAIL illegal_err got %b%b want %b%b", err_ovf, err_unf, m_ovf, m_unf);
    end
`endif
    set_roff(0, 1, 2, 5);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); checks++;
      if (rvalid[e.lane] !== e.v || (e.v && dout[e.lane*8 +: 8] !== e.d)) begin
        failures++; $display("FAIL illegal_lane%0d got v=%b d=%h want v=%b d=%h",
                             e.lane, rvalid[e.lane], dout[e.lane*8 +: 8], e.v, e.d);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1);
    for (int k = 0; k < 3; k++) cycle(1, 4, 32'h9A9B9C9D, 0, 0);
    wen = 1; wcnt = 3'd4; din = 32'h12345678; pop = 1; pop_cnt = 3'd2; rst = 1;
    @(posedge clk); #1;
    rst = 0; wen = 0; pop = 0;
    mq.delete();
`ifdef CWB_ERR_STICKY_EN
    m_ovf = 0; m_unf = 0;
`endif
    roff = {5'd3, 5'd2, 5'd1, 5'd0}; #1;
    checks++;
    if ({count, empty, rvalid} !== {6'd0, 1'b1, 4'b0000} || dout !== 32'h0) begin
      failures++; $display("FAIL reset_mid got cnt=%0d e=%b rv=%b d=%h want 0 1 0000 0",
                           count, empty, rvalid, dout);
    end
  endtask

  initial begin
    test_reset;
    test_append_read;
    test_fill;
    test_wrap;
    test_simul_illegal;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
